byte_to_lane_mapper: RTL and testbench

Transmit-side mainband mapper. Accepts one 64-byte flit per handshake and drives it onto the 32-bit-per-lane TX lanes. In 16-lane mode a flit takes 1 beat; in degraded 8-lane mode (lanes 0-7 or 8-15) it takes 2 beats. Byte order is the exact inverse of the RX lane-to-byte demapper, so a TX->RX loopback returns the original flit.

---
 rtl/mb_lane_pkg.sv | 37 +++
 rtl/lane_beat_slicer.sv | 55 +++++
 rtl/byte_to_lane_mapper.sv | 177 +++++++++++++++++
 tb/tb_byte_to_lane_mapper.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mb_lane_pkg.sv
// -----------------------------------------------------------------------------
// mb_lane_pkg
// Shared definitions for the mainband lane mapper (TX) and demapper (RX).
// Both sides import this package so the lane-mode encoding and the beat
// structure can never drift apart between transmitter and receiver.
//
// Contents:
//   LANES_*            functional-lane mode encodings
//   BYTES_PER_LANE     bytes carried by one lane in one beat
//   BEATS_8LANE/16LANE beats needed to move one flit in each lane mode
//   mapper_state_t     TX mapper FSM states
//   beats_for_mode()   beats per flit for a given lane mode
// -----------------------------------------------------------------------------
package mb_lane_pkg;

    localparam logic [1:0] LANES_NONE = 2'b00;
    localparam logic [1:0] LANES_0_7  = 2'b01;
    localparam logic [1:0] LANES_8_15 = 2'b10;
    localparam logic [1:0] LANES_0_15 = 2'b11;

    localparam int BYTES_PER_LANE = 4;
    localparam int BEATS_8LANE    = 2;
    localparam int BEATS_16LANE   = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } mapper_state_t;

    // Only the full-width mode moves a flit in one beat; both degraded
    // halves need two.
    function automatic int beats_for_mode(input logic [1:0] mode);
        return (mode == LANES_0_15) ? BEATS_16LANE : BEATS_8LANE;
    endfunction

endpackage

// File: rtl/lane_beat_slicer.sv
// -----------------------------------------------------------------------------
// lane_beat_slicer
// Combinational slicer: selects which bytes of a flit go onto which TX lane
// for a given lane mode and beat index. Lanes not used by the mode are zero.
//
// Ports:
//   i_flit   [8*N_BYTES-1:0]  flit, byte 0 in bits [7:0]
//   i_mode   [1:0]            lane mode (mb_lane_pkg LANES_*)
//   i_beat                    beat index within the flit (0 or 1)
//   o_lanes  [NUM_LANES]      per-lane word, WIDTH bits each
// -----------------------------------------------------------------------------
module lane_beat_slicer
    import mb_lane_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int N_BYTES   = 64,
    parameter int NUM_LANES = 16
) (
    input  logic [8*N_BYTES-1:0] i_flit,
    input  logic [1:0]           i_mode,
    input  logic                 i_beat,
    output logic [WIDTH-1:0]     o_lanes [NUM_LANES]
);

    localparam int HALF_LANES = NUM_LANES / BEATS_8LANE;
    localparam int HALF_BYTES = N_BYTES / BEATS_8LANE;

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            o_lanes[k] = '0;
        end
        case (i_mode)
            LANES_0_15: begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    o_lanes[k] = i_flit[k*BYTES_PER_LANE*8 +: WIDTH];
                end
            end
            // Degraded modes: beat 0 carries the low half of the flit,
            // beat 1 the high half; the lowest word of a half always goes
            // on the lowest lane of the active group.
            LANES_0_7: begin
                for (int k = 0; k < HALF_LANES; k++) begin
                    o_lanes[k] = i_flit[(int'(i_beat)*HALF_BYTES + k*BYTES_PER_LANE)*8 +: WIDTH];
                end
            end
            LANES_8_15: begin
                for (int k = 0; k < HALF_LANES; k++) begin
                    o_lanes[HALF_LANES+k] = i_flit[(int'(i_beat)*HALF_BYTES + k*BYTES_PER_LANE)*8 +: WIDTH];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/byte_to_lane_mapper.sv
// -----------------------------------------------------------------------------
// byte_to_lane_mapper
// Transmit-side mainband mapper. Accepts one flit per valid/ready handshake,
// buffers it with the lane mode sampled at accept, and drives it onto the TX
// lanes in one beat (16-lane mode) or two beats (8-lane modes). Byte order
// is the inverse of the RX demapper so TX->RX loopback returns the flit.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   enable_mapper             0 = idle (flush, outputs zero), 1 = operate
//   i_functional_tx_lanes     lane mode (01 = 0-7, 10 = 8-15, 11 = 0-15)
//   i_data, i_data_valid      offered flit
//   o_ready                   flit accepted when i_data_valid && o_ready
//   o_lane_0 .. o_lane_15     registered lane words
//   o_lane_valid              lanes carry a valid beat
//   o_flit_done               last beat of a flit
// -----------------------------------------------------------------------------
module byte_to_lane_mapper
    import mb_lane_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int N_BYTES   = 64,
    parameter int NUM_LANES = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 enable_mapper,
    input  logic [1:0]           i_functional_tx_lanes,
    input  logic [8*N_BYTES-1:0] i_data,
    input  logic                 i_data_valid,
    output logic                 o_ready,
    output logic [WIDTH-1:0]     o_lane_0,
    output logic [WIDTH-1:0]     o_lane_1,
    output logic [WIDTH-1:0]     o_lane_2,
    output logic [WIDTH-1:0]     o_lane_3,
    output logic [WIDTH-1:0]     o_lane_4,
    output logic [WIDTH-1:0]     o_lane_5,
    output logic [WIDTH-1:0]     o_lane_6,
    output logic [WIDTH-1:0]     o_lane_7,
    output logic [WIDTH-1:0]     o_lane_8,
    output logic [WIDTH-1:0]     o_lane_9,
    output logic [WIDTH-1:0]     o_lane_10,
    output logic [WIDTH-1:0]     o_lane_11,
    output logic [WIDTH-1:0]     o_lane_12,
    output logic [WIDTH-1:0]     o_lane_13,
    output logic [WIDTH-1:0]     o_lane_14,
    output logic [WIDTH-1:0]     o_lane_15,
    output logic                 o_lane_valid,
    output logic                 o_flit_done
);

    mapper_state_t        r_state;
    mapper_state_t        w_state_nxt;
    logic [8*N_BYTES-1:0] r_flit;
    logic [8*N_BYTES-1:0] w_flit_nxt;
    logic [1:0]           r_mode;
    logic [1:0]           w_mode_nxt;
    logic [WIDTH-1:0]     r_lanes [NUM_LANES];
    logic [WIDTH-1:0]     w_lanes [NUM_LANES];
    logic                 r_lane_valid;
    logic                 r_flit_done;
    logic                 w_last_beat;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_beat_nxt;
    logic                 w_valid_nxt;
    logic                 w_done_nxt;

    // The beat currently on the lanes is the last of its flit: a second beat,
    // or the only beat of a full-width flit. Accepting here gives
    // back-to-back flits without a bubble.
    assign w_last_beat = (r_state == ST_BEAT1) ||
                         ((r_state == ST_BEAT0) && (beats_for_mode(r_mode) == BEATS_16LANE));

    assign w_ready  = enable_mapper && (i_functional_tx_lanes != LANES_NONE) &&
                      ((r_state == ST_IDLE) || w_last_beat);
    assign w_accept = w_ready && i_data_valid;
    assign o_ready  = w_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_flit_nxt  = r_flit;
        w_mode_nxt  = r_mode;

        // Mode is only sampled here; later changes wait for the next accept.
        if (w_accept) begin
            w_flit_nxt = i_data;
            w_mode_nxt = i_functional_tx_lanes;
        end

        if (!enable_mapper) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) w_state_nxt = ST_BEAT0;
                end
                ST_BEAT0: begin
                    if (beats_for_mode(r_mode) == BEATS_8LANE) w_state_nxt = ST_BEAT1;
                    else if (w_accept)                         w_state_nxt = ST_BEAT0;
                    else                                       w_state_nxt = ST_IDLE;
                end
                ST_BEAT1: begin
                    w_state_nxt = w_accept ? ST_BEAT0 : ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        w_beat_nxt  = (w_state_nxt == ST_BEAT1);
        w_valid_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt  = (w_state_nxt == ST_BEAT1) ||
                      ((w_state_nxt == ST_BEAT0) && (beats_for_mode(w_mode_nxt) == BEATS_16LANE));
    end

    // The slicer looks at the beat about to be registered, so the lane
    // registers present it on the edge that enters that state.
    lane_beat_slicer #(
        .WIDTH     (WIDTH),
        .N_BYTES   (N_BYTES),
        .NUM_LANES (NUM_LANES)
    ) u_slicer (
        .i_flit  (w_flit_nxt),
        .i_mode  (w_mode_nxt),
        .i_beat  (w_beat_nxt),
        .o_lanes (w_lanes)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flit       <= '0;
            r_mode       <= LANES_NONE;
            r_lane_valid <= 1'b0;
            r_flit_done  <= 1'b0;
            for (int k = 0; k < NUM_LANES; k++) begin
                r_lanes[k] <= '0;
            end
        end else begin
            r_flit       <= w_flit_nxt;
            r_mode       <= w_mode_nxt;
            r_lane_valid <= w_valid_nxt;
            r_flit_done  <= w_done_nxt;
            // Lanes are forced to zero whenever no beat is valid.
            for (int k = 0; k < NUM_LANES; k++) begin
                r_lanes[k] <= w_valid_nxt ? w_lanes[k] : '0;
            end
        end
    end

    assign o_lane_valid = r_lane_valid;
    assign o_flit_done  = r_flit_done;
    assign o_lane_0     = r_lanes[0];
    assign o_lane_1     = r_lanes[1];
    assign o_lane_2     = r_lanes[2];
    assign o_lane_3     = r_lanes[3];
    assign o_lane_4     = r_lanes[4];
    assign o_lane_5     = r_lanes[5];
    assign o_lane_6     = r_lanes[6];
    assign o_lane_7     = r_lanes[7];
    assign o_lane_8     = r_lanes[8];
    assign o_lane_9     = r_lanes[9];
    assign o_lane_10    = r_lanes[10];
    assign o_lane_11    = r_lanes[11];
    assign o_lane_12    = r_lanes[12];
    assign o_lane_13    = r_lanes[13];
    assign o_lane_14    = r_lanes[14];
    assign o_lane_15    = r_lanes[15];

endmodule

// File: tb/tb_byte_to_lane_mapper.sv
// -----------------------------------------------------------------------------
// tb_byte_to_lane_mapper
// Bench for byte_to_lane_mapper. The reference model works at byte level:
// each accepted flit is expanded into the lane beats it must produce, and
// every valid beat is also folded back into a flit (RX-side view) and
// compared with what was sent.
// -----------------------------------------------------------------------------
module tb_byte_to_lane_mapper;

    localparam int WIDTH     = 32;
    localparam int N_BYTES   = 64;
    localparam int NUM_LANES = 16;
    localparam int FW        = 8*N_BYTES;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             en    = 1'b0;
    logic [1:0]       mode  = 2'b00;
    logic [FW-1:0]    data  = '0;
    logic             dv    = 1'b0;
    logic             ready;
    logic             lane_valid;
    logic             flit_done;
    logic [WIDTH-1:0] lane [NUM_LANES];

    always #5 clk = ~clk;

    byte_to_lane_mapper #(
        .WIDTH     (WIDTH),
        .N_BYTES   (N_BYTES),
        .NUM_LANES (NUM_LANES)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .enable_mapper         (en),
        .i_functional_tx_lanes (mode),
        .i_data                (data),
        .i_data_valid          (dv),
        .o_ready               (ready),
        .o_lane_0              (lane[0]),
        .o_lane_1              (lane[1]),
        .o_lane_2              (lane[2]),
        .o_lane_3              (lane[3]),
        .o_lane_4              (lane[4]),
        .o_lane_5              (lane[5]),
        .o_lane_6              (lane[6]),
        .o_lane_7              (lane[7]),
        .o_lane_8              (lane[8]),
        .o_lane_9              (lane[9]),
        .o_lane_10             (lane[10]),
        .o_lane_11             (lane[11]),
        .o_lane_12             (lane[12]),
        .o_lane_13             (lane[13]),
        .o_lane_14             (lane[14]),
        .o_lane_15             (lane[15]),
        .o_lane_valid          (lane_valid),
        .o_flit_done           (flit_done)
    );

    typedef struct packed { logic [FW-1:0] w; logic done; } beat_t;
    typedef struct packed { logic [FW-1:0] d; logic [1:0] m; } flit_t;

    beat_t         bq[$];
    flit_t         fq[$];
    logic [FW-1:0] rx_acc = '0;
    int            rx_beat = 0;
    int            n_acc = 0;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic chkw(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    endtask

    function automatic int nbeats(input logic [1:0] m);
        return (m == 2'b11) ? 1 : 2;
    endfunction

    function automatic int lane_base(input logic [1:0] m);
        return (m == 2'b10) ? 8 : 0;
    endfunction

    function automatic logic [FW-1:0] seq_flit(input int base);
        logic [FW-1:0] f;
        for (int i = 0; i < N_BYTES; i++) f[i*8 +: 8] = 8'(base + i);
        return f;
    endfunction

    function automatic logic [FW-1:0] rand_flit();
        logic [FW-1:0] f;
        for (int i = 0; i < FW/32; i++) f[i*32 +: 32] = $urandom();
        return f;
    endfunction

    // Byte i of a flit goes into beat i / (bytes per beat); within the beat,
    // consecutive groups of 4 bytes fill consecutive active lanes, LSB first.
    task automatic model_accept(input logic [FW-1:0] d, input logic [1:0] m);
        beat_t b [2];
        flit_t f;
        int    nb;
        int    bpb;
        nb   = nbeats(m);
        bpb  = N_BYTES / nb;
        b[0] = '0;
        b[1] = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            int bt;
            int off;
            int ln;
            bt  = i / bpb;
            off = i % bpb;
            ln  = lane_base(m) + off / 4;
            b[bt].w[ln*32 + (off%4)*8 +: 8] = d[i*8 +: 8];
        end
        b[nb-1].done = 1'b1;
        for (int j = 0; j < nb; j++) bq.push_back(b[j]);
        f.d = d;
        f.m = m;
        fq.push_back(f);
        n_acc++;
    endtask

    task automatic model_flush();
        bq.delete();
        fq.delete();
        rx_beat = 0;
        rx_acc  = '0;
    endtask

    task automatic check_outputs();
        beat_t         e;
        logic [FW-1:0] obs;
        logic          ev;
        for (int k = 0; k < NUM_LANES; k++) obs[k*32 +: 32] = lane[k];
        ev = (bq.size() > 0);
        e  = '0;
        if (ev) e = bq.pop_front();
        chk("lanes", obs, e.w);
        chk1("lane_valid", lane_valid, ev);
        chk1("flit_done", flit_done, e.done);
        // RX-side reassembly of the observed lanes back into a flit.
        if (ev && fq.size() > 0) begin
            int nb;
            int bpb;
            nb  = nbeats(fq[0].m);
            bpb = N_BYTES / nb;
            for (int i = 0; i < bpb; i++) begin
                int ln;
                ln = lane_base(fq[0].m) + i / 4;
                rx_acc[(rx_beat*bpb + i)*8 +: 8] = obs[ln*32 + (i%4)*8 +: 8];
            end
            rx_beat++;
            if (rx_beat == nb) begin
                chk("loopback", rx_acc, fq[0].d);
                fq.delete(0);
                rx_beat = 0;
                rx_acc  = '0;
            end
        end
    endtask

    // Called just after an active edge with new inputs already applied.
    task automatic cycle();
        logic exp_rdy;
        logic acc;
        #1;
        exp_rdy = en && (mode != 2'b00) && (bq.size() == 0);
        chk1("ready", ready, exp_rdy);
        acc = exp_rdy && dv;
        @(posedge clk);
        if (!en)      model_flush();
        else if (acc) model_accept(data, mode);
        #1;
        check_outputs();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_flush();
        check_outputs();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic random_run(input logic [1:0] m, input int target);
        int start;
        int budget;
        start  = n_acc;
        budget = 0;
        en     = 1'b1;
        mode   = m;
        while ((n_acc - start) < target && budget < 2000) begin
            dv   = ($urandom_range(0, 3) != 0);
            data = rand_flit();
            cycle();
            budget++;
        end
        if ((n_acc - start) < target) chk1("accept_budget", 1'b0, 1'b1);
        dv = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        // Reset state
        #3;
        check_outputs();
        chk1("ready_reset", ready, 1'b0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 16-lane mode, three back-to-back flits
        en = 1'b1; mode = 2'b11; dv = 1'b1; data = seq_flit(0);
        cycle();
        chkw("m11_lane0", lane[0], 32'h03020100);
        chkw("m11_lane15", lane[15], 32'h3F3E3D3C);
        data = seq_flit(8'h40);
        cycle();
        chkw("m11_f2_lane0", lane[0], 32'h43424140);
        data = seq_flit(8'h80);
        cycle();
        chkw("m11_f3_lane15", lane[15], 32'hBFBEBDBC);
        dv = 1'b0;
        cycle();
        cycle();

        // Lanes 0-7
        mode = 2'b01; dv = 1'b1; data = seq_flit(0);
        cycle();
        dv = 1'b0;
        chkw("m01_b0_lane0", lane[0], 32'h03020100);
        chkw("m01_b0_lane7", lane[7], 32'h1F1E1D1C);
        cycle();
        chkw("m01_b1_lane0", lane[0], 32'h23222120);
        chkw("m01_b1_lane7", lane[7], 32'h3F3E3D3C);
        chkw("m01_b1_lane8", lane[8], 32'h0);
        cycle();

        // Lanes 8-15
        mode = 2'b10; dv = 1'b1; data = seq_flit(0);
        cycle();
        dv = 1'b0;
        chkw("m10_b0_lane8", lane[8], 32'h03020100);
        chkw("m10_b0_lane0", lane[0], 32'h0);
        cycle();
        chkw("m10_b1_lane8", lane[8], 32'h23222120);
        cycle();

        // Mode change during beat 0 does not affect the in-flight flit
        mode = 2'b01; dv = 1'b1; data = seq_flit(0);
        cycle();
        mode = 2'b11; data = seq_flit(8'h40);
        cycle();
        chkw("mchg_b1_lane0", lane[0], 32'h23222120);
        chkw("mchg_b1_lane8", lane[8], 32'h0);
        cycle();
        chkw("mchg_next_lane15", lane[15], 32'h7F7E7D7C);
        dv = 1'b0;
        cycle();

        // Enable dropped during beat 0, then a fresh flit
        mode = 2'b01; dv = 1'b1; data = seq_flit(0);
        cycle();
        dv = 1'b0; en = 1'b0;
        cycle();
        chk1("disable_valid", lane_valid, 1'b0);
        en = 1'b1; dv = 1'b1; data = seq_flit(8'h40);
        cycle();
        dv = 1'b0;
        chkw("reenable_b0_lane0", lane[0], 32'h43424140);
        cycle();
        cycle();

        // Mode 00 while a two-beat flit is in flight
        mode = 2'b10; dv = 1'b1; data = seq_flit(8'h10);
        cycle();
        mode = 2'b00;
        cycle();
        dv = 1'b0;
        cycle();

        // Asynchronous reset mid-flit
        mode = 2'b01; dv = 1'b1; data = seq_flit(0);
        cycle();
        dv = 1'b0;
        async_reset();
        cycle();
        cycle();

        // Random flits in each mode with RX-side reassembly
        random_run(2'b11, 100);
        random_run(2'b01, 100);
        random_run(2'b10, 100);

        // Random mode, enable and valid mix
        for (int n = 0; n < 400; n++) begin
            en   = ($urandom_range(0, 9) != 0);
            mode = 2'($urandom_range(0, 3));
            dv   = ($urandom_range(0, 3) != 0);
            data = rand_flit();
            cycle();
        end
        en = 1'b1; dv = 1'b0;
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
